// File: rtl/mem_stage_responder.sv
// Memory-stage responder: turns EXE-to-MEM load/store requests into SRAM req/ack transactions.
// Optional build macro MEM_TIMEOUT_EN adds an ack timeout with a sticky mem_error flag.
module mem_stage_responder #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_read_enabled,
    input  logic              memory_write_enabled,
    input  logic [DATA_W-1:0] alu_unit_result,
    input  logic [DATA_W-1:0] STVal,
    output logic              freeze,
    output logic [DATA_W-1:0] memReadVal,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_error
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e            state_q;
    logic              req_v;
    logic [DATA_W-1:0] offset;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr_bits;

    assign req_v  = memory_read_enabled | memory_write_enabled;
    assign freeze = req_v & (state_q != StDone);

    // Below-base addresses wrap naturally through the subtraction.
    assign offset           = alu_unit_result - DATA_W'(BASE_ADDR);
    assign word_addr        = offset[ADDR_W+1:2];
    assign unused_addr_bits = ^{offset[1:0], offset[DATA_W-1:ADDR_W+2]};

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] count_q;
    logic             error_q;

    assign mem_error = error_q;
`else
    assign mem_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            memReadVal <= '0;
`ifdef MEM_TIMEOUT_EN
            count_q    <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_v) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memory_write_enabled;
                        mem_addr  <= word_addr;
                        mem_wdata <= STVal;
                        state_q   <= StReq;
`ifdef MEM_TIMEOUT_EN
                        count_q   <= '0;
`endif
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            memReadVal <= mem_rdata;
                        end
                        state_q <= StDone;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Last permitted REQ cycle without ack: give up and poison the load.
                    else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            memReadVal <= '1;
                        end
                        error_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_responder.sv
// Self-checking bench for mem_stage_responder: directed cases then randomized transactions
// checked against a transaction-level reference model.
module tb_mem_stage_responder;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
    localparam int unsigned MAX_DELAY = 2;
`else
    localparam int unsigned TMO = 255;
    localparam int unsigned MAX_DELAY = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_read_enabled, memory_write_enabled;
    logic [31:0] alu_unit_result, STVal;
    logic        freeze;
    logic [31:0] memReadVal;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        mem_error;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_rd  = '0;
    logic        exp_err = 1'b0;

    mem_stage_responder #(
        .DATA_W   (32),
        .ADDR_W   (16),
        .BASE_ADDR(1024),
        .TIMEOUT  (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .memory_read_enabled (memory_read_enabled),
        .memory_write_enabled(memory_write_enabled),
        .alu_unit_result     (alu_unit_result),
        .STVal               (STVal),
        .freeze              (freeze),
        .memReadVal          (memReadVal),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_ack             (mem_ack),
        .mem_error           (mem_error)
    );

    always #5 clk = ~clk;

    // Word index relative to the SRAM base, modulo the 2^16-word SRAM.
    function automatic logic [31:0] ref_addr(input logic [31:0] a);
        return ((a - 32'd1024) / 32'd4) % 32'd65536;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, entered with the DUT idle just after a clock edge.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] stv, input logic [31:0] rdata, input int delay);
        int fz = 0;
        memory_read_enabled  = rd;
        memory_write_enabled = wr;
        alu_unit_result      = addr;
        STVal                = stv;
        @(negedge clk);
        fz += int'(freeze);
        chk("idle_req", mem_req, 1'b0);
        for (int k = 0; k <= delay; k++) begin
            step();
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : $urandom;
            @(negedge clk);
            fz += int'(freeze);
            chk("req_hi", mem_req, 1'b1);
            chk("req_addr", mem_addr, ref_addr(addr));
            chk("req_we", mem_we, wr);
            chk("req_wdata", mem_wdata, stv);
        end
        step();
        mem_ack = 1'b0;
        if (rd && !wr) exp_rd = rdata;
        @(negedge clk);
        chk("done_freeze", freeze, 1'b0);
        chk("done_req", mem_req, 1'b0);
        chk("done_rdval", memReadVal, exp_rd);
        chk("done_err", mem_error, exp_err);
        chk("freeze_cycles", fz, delay + 2);
        step();
        memory_read_enabled  = 1'b0;
        memory_write_enabled = 1'b0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_freeze0", freeze, 1'b0);
        chk("idle_hold", memReadVal, exp_rd);
        step();
    endtask

    initial begin
        reset = 1'b1;
        memory_read_enabled = 1'b0;
        memory_write_enabled = 1'b0;
        alu_unit_result = '0;
        STVal = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdval", memReadVal, 32'h0);
        chk("rst_err", mem_error, 1'b0);
        step();
        reset = 1'b0;
        // Ack while idle must do nothing.
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        idle_check();

        txn(1'b1, 1'b0, 32'd1032, 32'h0, 32'h1234ABCD, 2);
        idle_check();
        txn(1'b0, 1'b1, 32'd1044, 32'hCAFEF00D, 32'h55555555, 0);
        txn(1'b1, 1'b1, 32'd1028, 32'h0BADCAFE, 32'h77777777, 1);
        txn(1'b1, 1'b0, 32'd1027, 32'h0, 32'hA5A5A5A5, 0);
        txn(1'b1, 1'b0, 32'd1020, 32'h0, 32'h13579BDF, 0);
        txn(1'b1, 1'b0, 32'd1036, 32'h0, 32'h00000003, 1);
        txn(1'b1, 1'b0, 32'd1040, 32'h0, 32'h00000004, 1);
        idle_check();

        // Reset while in REQ, then a late ack.
        memory_read_enabled = 1'b1;
        alu_unit_result = 32'd1100;
        step();
        @(negedge clk);
        chk("abort_req_hi", mem_req, 1'b1);
        step();
        reset = 1'b1;
        memory_read_enabled = 1'b0;
        step();
        reset = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        chk("abort_req", mem_req, 1'b0);
        chk("abort_addr", mem_addr, 16'h0);
        chk("abort_rdval", memReadVal, 32'h0);
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'hFEEDFACE;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", mem_req, 1'b0);
        chk("late_ack_rdval", memReadVal, 32'h0);
        step();

        for (int i = 0; i < 30; i++) begin
            logic        rd, wr;
            logic [31:0] a;
            int unsigned kind = $urandom_range(2, 0);
            rd = (kind != 1);
            wr = (kind != 0);
            a = ($urandom_range(1, 0) == 1) ? $urandom : 32'd1024 + $urandom_range(4095, 0);
            txn(rd, wr, a, $urandom, $urandom, int'($urandom_range(MAX_DELAY, 0)));
            if ($urandom_range(1, 0) == 1) idle_check();
        end

`ifdef MEM_TIMEOUT_EN
        memory_read_enabled = 1'b1;
        alu_unit_result = 32'd1048;
        step();
        for (int k = 0; k < int'(TMO); k++) begin
            @(negedge clk);
            chk("tmo_req_hi", mem_req, 1'b1);
            step();
        end
        @(negedge clk);
        exp_rd = 32'hFFFFFFFF;
        exp_err = 1'b1;
        chk("tmo_req", mem_req, 1'b0);
        chk("tmo_rdval", memReadVal, exp_rd);
        chk("tmo_err", mem_error, exp_err);
        step();
        memory_read_enabled = 1'b0;
        idle_check();
        txn(1'b1, 1'b0, 32'd1052, 32'h0, 32'h2468ACE0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
